// File: rtl/ls138_scan_ctrl.sv
// ls138_scan_ctrl
//   Sequencer that drives the select and enable inputs of a 74138 3-to-8
//   decoder through a line scan. Each enabled line is held active for a
//   programmable dwell time and masked lines are skipped.
//
//   Optional feature macro: LS138_SCAN_BLANK_EN
//     defined   : one blank cycle (enables off) is inserted between lines,
//                 so the line period is dwell+1 cycles.
//     undefined : after the initial blank that follows a start, lines change
//                 ACTIVE->ACTIVE with enables held on; line period is dwell.
//
//   Handshake: start_i is a level sampled on the rising edge and accepted
//   only in IDLE with a nonzero effective mask. stop_i is sampled in any busy
//   cycle, remembered, and honoured when the current line's dwell completes.
//   There is no ready/ack; busy_o tells the requester whether a scan runs.
//
//   Ports
//     clk_i, rst_n_i            clock, synchronous active-low reset
//     start_i, stop_i           scan start / stop request
//     dwell_i [DWELL_W]         active cycles per line (0 behaves as 1)
//     mask_i  [8]               per-line enable (bit n scans line n)
//     select_{a,b,c}_o          decoder select inputs A/B/C (line bit 0/1/2)
//     g1_en_o, g2a/g2b_en_n_o   decoder enables (G1 high-true, G2A/G2B low)
//     busy_o                    scan in progress
//     line_done_o               one-cycle pulse after each completed dwell
//     frame_done_o              one-cycle pulse after the last line of a frame
//     state_dbg_o [2]           current FSM state (IDLE=0, BLANK=1, ACTIVE=2)
module ls138_scan_ctrl #(
  parameter int DWELL_W   = 16,
  parameter int LAST_LINE = 7
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [7:0]         mask_i,
  output logic               select_a_o,
  output logic               select_b_o,
  output logic               select_c_o,
  output logic               g1_en_o,
  output logic               g2a_en_n_o,
  output logic               g2b_en_n_o,
  output logic               busy_o,
  output logic               line_done_o,
  output logic               frame_done_o,
  output logic [1:0]         state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Lines above LAST_LINE are never scanned, whatever the mask says.
  localparam logic [7:0] LINE_MASK = 8'(8'hFF >> (7 - LAST_LINE));

  state_t             state_q, state_d;
  logic [2:0]         line_q, line_d;
  logic               en_q, en_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         mask_q, mask_d;
  logic               stop_pend_q, stop_pend_d;
  logic               line_done_q, line_done_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;

  logic [7:0]         eff_mask;
  logic [3:0]         above;
  logic [2:0]         next_line;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [3:0] next_above(input logic [7:0] m,
                                            input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign eff_mask  = mask_i & LINE_MASK;
  assign above     = next_above(mask_q, line_q);
  // No higher line left means this line closes the frame; wrap around.
  assign next_line = above[3] ? above[2:0] : lowest_set(mask_q);

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    en_d         = en_q;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    mask_d       = mask_q;
    stop_pend_d  = stop_pend_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        en_d        = 1'b0;
        stop_pend_d = 1'b0;
        if (start_i && (eff_mask != 8'd0)) begin
          mask_d  = eff_mask;
          dwell_d = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
          line_d  = lowest_set(eff_mask);
          state_d = BLANK;
        end
      end

      BLANK: begin
        if (stop_i) stop_pend_d = 1'b1;
        en_d    = 1'b1;
        cnt_d   = dwell_q - DWELL_W'(1);
        state_d = ACTIVE;
      end

      ACTIVE: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          line_done_d  = 1'b1;
          frame_done_d = ~above[3];
          if (stop_pend_q || stop_i) begin
            // Selects hold the finished line while parked in IDLE.
            state_d     = IDLE;
            en_d        = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
`ifdef LS138_SCAN_BLANK_EN
            state_d = BLANK;
            line_d  = next_line;
            en_d    = 1'b0;
`else
            state_d = ACTIVE;
            line_d  = next_line;
            en_d    = 1'b1;
            cnt_d   = dwell_q - DWELL_W'(1);
`endif
          end
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      line_q       <= 3'd0;
      en_q         <= 1'b0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      mask_q       <= 8'd0;
      stop_pend_q  <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      en_q         <= en_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      mask_q       <= mask_d;
      stop_pend_q  <= stop_pend_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign select_a_o   = line_q[0];
  assign select_b_o   = line_q[1];
  assign select_c_o   = line_q[2];
  assign g1_en_o      = en_q;
  assign g2a_en_n_o   = ~en_q;
  assign g2b_en_n_o   = ~en_q;
  assign busy_o       = busy_q;
  assign line_done_o  = line_done_q;
  assign frame_done_o = frame_done_q;
  assign state_dbg_o  = state_q;

endmodule
